p3_buf_ctrl: RTL and testbench
==============================

P3_BUF_CTRL -- requirements
Module: p3_buf_ctrl

Interface
REQ-001 Parameters SHALL be: CNT_WIDTH, 16, width of the accepted and rejected packet counters.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, as listed below.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 sn_done  in  1  snooper has finished writing the packet into its granted buffer.
REQ-006 cpu_acc  in  1  CPU accepts the packet in its granted buffer.
REQ-007 cpu_rej  in  1  CPU rejects the packet in its granted buffer.
REQ-008 fwd_done  in  1  forwarder has finished reading its granted buffer.
REQ-009 sn_sel, cpu_sel, fwd_sel  out  2 each  buffer owned by each agent: 00 none, 01 ping, 10 pang, 11 pong.
REQ-010 ping_sel, pang_sel, pong_sel  out  2 each  agent owning each buffer: 00 none, 01 snooper, 10 CPU, 11 forwarder.
REQ-011 sn_rdy, cpu_rdy, fwd_rdy  out  1 each  asserted when that agent's sel is not 00.
REQ-012 acc_cnt, rej_cnt  out  CNT_WIDTH each  running totals of accepted and rejected packets.

Function
REQ-013 Each buffer SHALL hold one state: FREE, SN, FILLED, CPU, ACC or FWD; all sel outputs are registered and derived only from these states.
REQ-014 Transitions SHALL be:
- FREE->SN on snooper grant
- SN->FILLED on sn_done
- FILLED->CPU on CPU grant
- CPU->ACC on cpu_acc
- CPU->FREE on cpu_rej
- ACC->FWD on forwarder grant
- FWD->FREE on fwd_done
REQ-015 Snooper grant SHALL occur when no buffer is in SN and at least one buffer is FREE; the lowest-index FREE buffer is granted (ping before pang before pong).
REQ-016 CPU grant SHALL occur when no buffer is in CPU and at least one buffer is FILLED; the oldest FILLED buffer is granted.
REQ-017 Forwarder grant SHALL occur when no buffer is in FWD and at least one buffer is ACC; the oldest ACC buffer is granted.
REQ-018 Age SHALL be tracked by a 3x3 older-than relation; on sn_done for buffer i, i becomes younger than both other buffers; all other pairs are unchanged.
REQ-019 Grant candidates SHALL be evaluated from current-cycle state only; a buffer released in cycle N is grantable no earlier than N+1, and its new sel appears at N+2.
REQ-020 Done/acc/rej inputs SHALL be ignored when the corresponding agent holds no buffer.
REQ-021 A sel SHALL drop to 00 in the cycle after its done/acc/rej is sampled; the agent's next grant is earliest one cycle later.
REQ-022 When cpu_acc and cpu_rej are asserted together, reject SHALL win.
REQ-023 Releases and grants by different agents in the same cycle SHALL all take effect independently.
REQ-024 acc_cnt SHALL increment by one on each honoured accept, rej_cnt on each honoured reject; both wrap modulo 2^CNT_WIDTH.
REQ-025 No buffer SHALL ever be owned by two agents, and no agent SHALL own two buffers.

Reset
REQ-026 While rst is high on a clock edge: all buffers SHALL be FREE; all sel, rdy and counter outputs 0; age order ping older than pang older than pong.
REQ-027 Reset asserted mid-operation SHALL abandon all packets without incrementing either counter.
REQ-028 The first snooper grant (sn_sel=01, ping_sel=01) SHALL appear on the second edge after rst deasserts.

Verification
REQ-029 Reset then idle -> sn_sel=01, ping_sel=01, sn_rdy=1; cpu_sel=fwd_sel=00.
REQ-030 sn_done once -> ping becomes FILLED then CPU (cpu_sel=01, ping_sel=10); snooper moves to pang (sn_sel=10, pang_sel=01).
REQ-031 Fill ping, pang, pong with CPU stalled -> sn_sel=00, sn_rdy=0 once all three are non-FREE; cpu_acc then grants CPU pang (older than pong).
REQ-032 cpu_acc and cpu_rej pulsed together on ping -> ping becomes FREE, rej_cnt=1, acc_cnt=0, fwd_sel stays 00.
REQ-033 Same-cycle sn_done on pang, cpu_acc on ping and fwd_done on pong -> next cycle pang FILLED, ping ACC, pong FREE; following cycle cpu_sel=10, fwd_sel=01, sn_sel=11.
REQ-034 rst pulsed while forwarder holds ping -> all sel outputs 00 and counters 0; the snooper is regranted ping as in REQ-028.

Source files
------------

// File: rtl/p3_buf_ctrl.sv
// p3_buf_ctrl: owns the three packet buffers (ping, pang, pong) and hands
// them round snooper -> CPU -> forwarder. Each buffer carries one state; the
// sel outputs are a registered view of those states, so a grant made on one
// edge is visible to the agent on the next edge.
module p3_buf_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sn_done,
  input  logic                 cpu_acc,
  input  logic                 cpu_rej,
  input  logic                 fwd_done,
  output logic [1:0]           sn_sel,
  output logic [1:0]           cpu_sel,
  output logic [1:0]           fwd_sel,
  output logic [1:0]           ping_sel,
  output logic [1:0]           pang_sel,
  output logic [1:0]           pong_sel,
  output logic                 sn_rdy,
  output logic                 cpu_rdy,
  output logic                 fwd_rdy,
  output logic [CNT_WIDTH-1:0] acc_cnt,
  output logic [CNT_WIDTH-1:0] rej_cnt
);

  typedef enum logic [2:0] {
    B_FREE, B_SN, B_FILLED, B_CPU, B_ACC, B_FWD
  } buf_st_t;

  buf_st_t          st     [3];
  buf_st_t          st_nxt [3];
  // older[i][j] set means buffer i was filled before buffer j
  logic [2:0][2:0]  older, older_nxt;

  logic       has_sn, has_cpu, has_fwd;
  logic [2:0] sn_gnt, cpu_gnt, fwd_gnt;
  logic       sn_fin, acc_fin, rej_fin, fwd_fin;
  logic [1:0] sn_code, cpu_code, fwd_code;
  logic [1:0] own_code [3];

  // Occupancy, grant arbitration and per-agent/per-buffer codes, all from the
  // current registered state only.
  always_comb begin
    logic ok;
    logic found;
    has_sn   = 1'b0;
    has_cpu  = 1'b0;
    has_fwd  = 1'b0;
    sn_code  = 2'd0;
    cpu_code = 2'd0;
    fwd_code = 2'd0;
    for (int i = 0; i < 3; i++) begin
      own_code[i] = 2'd0;
      if (st[i] == B_SN)  begin has_sn  = 1'b1; sn_code  = 2'(i + 1); own_code[i] = 2'd1; end
      if (st[i] == B_CPU) begin has_cpu = 1'b1; cpu_code = 2'(i + 1); own_code[i] = 2'd2; end
      if (st[i] == B_FWD) begin has_fwd = 1'b1; fwd_code = 2'(i + 1); own_code[i] = 2'd3; end
    end

    // snooper takes the lowest-index free buffer
    sn_gnt = 3'b000;
    found  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!has_sn && !found && st[i] == B_FREE) begin
        sn_gnt[i] = 1'b1;
        found     = 1'b1;
      end
    end

    // CPU and forwarder take the oldest buffer in their input state
    cpu_gnt = 3'b000;
    fwd_gnt = 3'b000;
    for (int i = 0; i < 3; i++) begin
      ok = !has_cpu && (st[i] == B_FILLED);
      for (int j = 0; j < 3; j++)
        if (j != i && st[j] == B_FILLED && !older[i][j]) ok = 1'b0;
      cpu_gnt[i] = ok;
      ok = !has_fwd && (st[i] == B_ACC);
      for (int j = 0; j < 3; j++)
        if (j != i && st[j] == B_ACC && !older[i][j]) ok = 1'b0;
      fwd_gnt[i] = ok;
    end

    // releases only count when the agent actually holds a buffer; reject wins
    sn_fin  = sn_done  && has_sn;
    rej_fin = cpu_rej  && has_cpu;
    acc_fin = cpu_acc  && !cpu_rej && has_cpu;
    fwd_fin = fwd_done && has_fwd;
  end

  // Per-buffer next state and age update; grants and releases touch disjoint
  // states, so all of them can land on the same edge.
  always_comb begin
    older_nxt = older;
    for (int i = 0; i < 3; i++) begin
      st_nxt[i] = st[i];
      case (st[i])
        B_FREE:   if (sn_gnt[i])  st_nxt[i] = B_SN;
        B_SN:     if (sn_fin) begin
                    st_nxt[i] = B_FILLED;
                    for (int j = 0; j < 3; j++) begin
                      if (j != i) begin
                        older_nxt[i][j] = 1'b0;
                        older_nxt[j][i] = 1'b1;
                      end
                    end
                  end
        B_FILLED: if (cpu_gnt[i]) st_nxt[i] = B_CPU;
        B_CPU:    if (rej_fin)    st_nxt[i] = B_FREE;
                  else if (acc_fin) st_nxt[i] = B_ACC;
        B_ACC:    if (fwd_gnt[i]) st_nxt[i] = B_FWD;
        B_FWD:    if (fwd_fin)    st_nxt[i] = B_FREE;
        default:  st_nxt[i] = B_FREE;
      endcase
    end
  end

  // State, age, registered sel view and packet counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) st[i] <= B_FREE;
      older       <= '0;
      older[0][1] <= 1'b1;
      older[0][2] <= 1'b1;
      older[1][2] <= 1'b1;
      sn_sel      <= 2'd0;
      cpu_sel     <= 2'd0;
      fwd_sel     <= 2'd0;
      ping_sel    <= 2'd0;
      pang_sel    <= 2'd0;
      pong_sel    <= 2'd0;
      acc_cnt     <= '0;
      rej_cnt     <= '0;
    end else begin
      for (int i = 0; i < 3; i++) st[i] <= st_nxt[i];
      older    <= older_nxt;
      sn_sel   <= sn_code;
      cpu_sel  <= cpu_code;
      fwd_sel  <= fwd_code;
      ping_sel <= own_code[0];
      pang_sel <= own_code[1];
      pong_sel <= own_code[2];
      if (acc_fin) acc_cnt <= acc_cnt + CNT_WIDTH'(1);
      if (rej_fin) rej_cnt <= rej_cnt + CNT_WIDTH'(1);
    end
  end

  assign sn_rdy  = |sn_sel;
  assign cpu_rdy = |cpu_sel;
  assign fwd_rdy = |fwd_sel;

endmodule

// File: tb/tb_p3_buf_ctrl.sv
// Bench for p3_buf_ctrl: directed scenarios plus random traffic, every cycle
// compared against a buffer-lifecycle model (state per buffer, fill-order queue).
module tb_p3_buf_ctrl;
  localparam int CW = 4;  // narrow counters so wrap-around is reached

  logic          clk = 1'b0;
  logic          rst, sn_done, cpu_acc, cpu_rej, fwd_done;
  logic [1:0]    sn_sel, cpu_sel, fwd_sel, ping_sel, pang_sel, pong_sel;
  logic          sn_rdy, cpu_rdy, fwd_rdy;
  logic [CW-1:0] acc_cnt, rej_cnt;

  p3_buf_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .sn_done(sn_done), .cpu_acc(cpu_acc),
    .cpu_rej(cpu_rej), .fwd_done(fwd_done),
    .sn_sel(sn_sel), .cpu_sel(cpu_sel), .fwd_sel(fwd_sel),
    .ping_sel(ping_sel), .pang_sel(pang_sel), .pong_sel(pong_sel),
    .sn_rdy(sn_rdy), .cpu_rdy(cpu_rdy), .fwd_rdy(fwd_rdy),
    .acc_cnt(acc_cnt), .rej_cnt(rej_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model ----
  localparam int FREE = 0, SN = 1, FILLED = 2, CPU = 3, ACC = 4, FWD = 5;
  int m_st [3];
  int m_age [$];      // buffers in fill order, oldest first
  int e_ag [3];       // expected sel per agent: snooper, CPU, forwarder
  int e_bf [3];       // expected owner per buffer: ping, pang, pong
  int e_acc, e_rej;

  function automatic bit in_use(input int s);
    for (int b = 0; b < 3; b++) if (m_st[b] == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model(input bit sd, input bit ca, input bit cr, input bit fd, input bit r);
    int ns [3];
    if (r) begin
      for (int b = 0; b < 3; b++) begin m_st[b] = FREE; e_ag[b] = 0; e_bf[b] = 0; end
      m_age = '{0, 1, 2};
      e_acc = 0; e_rej = 0;
      return;
    end
    // outputs after this edge show the states held before it
    for (int b = 0; b < 3; b++) begin e_ag[b] = 0; e_bf[b] = 0; end
    for (int b = 0; b < 3; b++) begin
      if (m_st[b] == SN)  begin e_ag[0] = b + 1; e_bf[b] = 1; end
      if (m_st[b] == CPU) begin e_ag[1] = b + 1; e_bf[b] = 2; end
      if (m_st[b] == FWD) begin e_ag[2] = b + 1; e_bf[b] = 3; end
    end
    ns = m_st;
    if (!in_use(SN))
      for (int b = 0; b < 3; b++) if (m_st[b] == FREE) begin ns[b] = SN; break; end
    if (!in_use(CPU))
      foreach (m_age[k]) if (m_st[m_age[k]] == FILLED) begin ns[m_age[k]] = CPU; break; end
    if (!in_use(FWD))
      foreach (m_age[k]) if (m_st[m_age[k]] == ACC) begin ns[m_age[k]] = FWD; break; end
    for (int b = 0; b < 3; b++) begin
      if (m_st[b] == SN && sd) begin
        ns[b] = FILLED;
        foreach (m_age[k]) if (m_age[k] == b) begin m_age.delete(k); break; end
        m_age.push_back(b);
      end
      if (m_st[b] == CPU && cr)      begin ns[b] = FREE; e_rej = (e_rej + 1) % (1 << CW); end
      else if (m_st[b] == CPU && ca) begin ns[b] = ACC;  e_acc = (e_acc + 1) % (1 << CW); end
      if (m_st[b] == FWD && fd) ns[b] = FREE;
    end
    m_st = ns;
  endtask

  // one clock: drive, let the edge happen, then compare on the falling edge
  task automatic step(input bit sd, input bit ca, input bit cr, input bit fd, input bit r);
    sn_done = sd; cpu_acc = ca; cpu_rej = cr; fwd_done = fd; rst = r;
    @(posedge clk);
    model(sd, ca, cr, fd, r);
    @(negedge clk);
    chk("sn_sel",   sn_sel,   e_ag[0]);
    chk("cpu_sel",  cpu_sel,  e_ag[1]);
    chk("fwd_sel",  fwd_sel,  e_ag[2]);
    chk("ping_sel", ping_sel, e_bf[0]);
    chk("pang_sel", pang_sel, e_bf[1]);
    chk("pong_sel", pong_sel, e_bf[2]);
    chk("sn_rdy",   sn_rdy,   e_ag[0] != 0);
    chk("cpu_rdy",  cpu_rdy,  e_ag[1] != 0);
    chk("fwd_rdy",  fwd_rdy,  e_ag[2] != 0);
    chk("acc_cnt",  acc_cnt,  e_acc);
    chk("rej_cnt",  rej_cnt,  e_rej);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    sn_done = 0; cpu_acc = 0; cpu_rej = 0; fwd_done = 0; rst = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_sn_sel", sn_sel, 0);
    chk("rst_acc", acc_cnt, 0);

    // boot: grant lands on the second edge after reset
    idle(1);
    chk("boot_e1_sn_sel", sn_sel, 0);
    idle(1);
    chk("boot_sn_sel", sn_sel, 1);
    chk("boot_ping_sel", ping_sel, 1);
    chk("boot_cpu_sel", cpu_sel, 0);

    // first packet: CPU gets ping, snooper moves to pang
    step(1, 0, 0, 0, 0);
    idle(2);
    chk("p1_cpu_sel", cpu_sel, 1);
    chk("p1_ping_sel", ping_sel, 2);
    chk("p1_sn_sel", sn_sel, 2);
    chk("p1_pang_sel", pang_sel, 1);

    // fill pang then pong while CPU sits on ping
    step(1, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    idle(2);
    chk("full_sn_sel", sn_sel, 0);
    chk("full_sn_rdy", sn_rdy, 0);
    step(0, 1, 0, 0, 0);
    idle(2);
    chk("full_cpu_sel_pang", cpu_sel, 2);
    chk("full_fwd_sel_ping", fwd_sel, 1);
    chk("full_acc", acc_cnt, 1);

    // reset while the forwarder holds ping
    step(0, 0, 0, 0, 1);
    chk("mid_rst_fwd_sel", fwd_sel, 0);
    chk("mid_rst_acc", acc_cnt, 0);
    idle(2);
    chk("mid_rst_sn_sel", sn_sel, 1);
    chk("mid_rst_ping_sel", ping_sel, 1);

    // accept and reject together: reject wins
    step(1, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 1, 0, 0);
    idle(1);
    chk("accrej_ping_sel", ping_sel, 0);
    chk("accrej_rej", rej_cnt, 1);
    chk("accrej_acc", acc_cnt, 0);
    chk("accrej_fwd_sel", fwd_sel, 0);

    // random traffic with the occasional reset
    for (int c = 0; c < 4000; c++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 299) == 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
